framebuffer_scanout_reader: RTL and testbench

// - Read side of the dual-port framebuffer: a VGA scan-out engine on the pixel clock.
// - Generates 640x480@60 timing (800x525 total) and walks the 160x120 buffer in raster order.
// - Each buffer pixel is replicated SCALE x SCALE on screen.
// - Drives read_addr into the RAM read port, takes back q and produces colour plus syncs.
// - Also exports a frame_start pulse so the writer can align its updates.

---
 rtl/framebuffer_scanout_reader.sv | 145 ++++++++++++++
 tb/tb_framebuffer_scanout_reader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_scanout_reader.sv
// rtl/framebuffer_scanout_reader.sv - VGA scan-out reader walking a scaled framebuffer
// Counters, address generator and 3-stage pipeline from counter value to pins.
module framebuffer_scanout_reader #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 15,
  parameter int FB_WIDTH   = 160,
  parameter int FB_HEIGHT  = 120,
  parameter int SCALE      = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic                  read_clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] q,
  output logic [11:0]           rgb,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  active,
  output logic                  frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [9:0]            H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]            V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]            H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0]            V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0]            H_VIS_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0]            HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]            HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]            VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]            VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [XW-1:0]         SUB_LAST = XW'(SCALE - 1);
  localparam logic [XW-1:0]         SUB_ONE  = XW'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(FB_WIDTH);

  logic [9:0]            h_count, v_count;
  logic                  h_last, frame_last;
  logic                  vis, hs, vs, fs;
  logic [XW-1:0]         x_sub, y_sub;
  logic [ADDR_WIDTH-1:0] fb_x, line_base;
  logic                  vis_d1, vis_d2, hs_d1, hs_d2, vs_d1, vs_d2, fs_d1, fs_d2;

  assign h_last     = (h_count == H_LAST);
  assign frame_last = h_last && (v_count == V_LAST);

  always_ff @(posedge read_clock) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_last) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
    end else begin
      h_count <= h_count + 10'd1;
    end
  end

  always_comb begin
    vis = (h_count < H_VIS) && (v_count < V_VIS);
    hs  = !((h_count >= HS_START) && (h_count < HS_END));
    vs  = !((v_count >= VS_START) && (v_count < VS_END));
    fs  = (h_count == 10'd0) && (v_count == 10'd0);
  end

  // Address is walked incrementally so no multiplier is needed for y*FB_WIDTH.
  always_ff @(posedge read_clock) begin
    if (reset || frame_last) begin
      x_sub     <= '0;
      y_sub     <= '0;
      fb_x      <= '0;
      line_base <= '0;
    end else if (vis) begin
      if (h_count == H_VIS_LAST) begin
        x_sub <= '0;
        fb_x  <= '0;
        if (y_sub == SUB_LAST) begin
          y_sub     <= '0;
          line_base <= line_base + ROW_STEP;
        end else begin
          y_sub <= y_sub + SUB_ONE;
        end
      end else if (x_sub == SUB_LAST) begin
        x_sub <= '0;
        fb_x  <= fb_x + ADDR_ONE;
      end else begin
        x_sub <= x_sub + SUB_ONE;
      end
    end
  end

  always_ff @(posedge read_clock) begin
    if (reset) begin
      read_addr <= '0;
    end else if (vis) begin
      read_addr <= line_base + fb_x;
    end
  end

  // Sync/enable decodes ride along with the RAM access so they stay aligned with rgb.
  always_ff @(posedge read_clock) begin
    if (reset) begin
      vis_d1      <= 1'b0;
      vis_d2      <= 1'b0;
      hs_d1       <= 1'b1;
      hs_d2       <= 1'b1;
      vs_d1       <= 1'b1;
      vs_d2       <= 1'b1;
      fs_d1       <= 1'b0;
      fs_d2       <= 1'b0;
      rgb         <= 12'h000;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vis_d1      <= vis;
      vis_d2      <= vis_d1;
      hs_d1       <= hs;
      hs_d2       <= hs_d1;
      vs_d1       <= vs;
      vs_d2       <= vs_d1;
      fs_d1       <= fs;
      fs_d2       <= fs_d1;
      rgb         <= vis_d2 ? ((|q) ? FG_COLOR : BG_COLOR) : 12'h000;
      hsync       <= hs_d2;
      vsync       <= vs_d2;
      active      <= vis_d2;
      frame_start <= fs_d2;
    end
  end

endmodule

// File: tb/tb_framebuffer_scanout_reader.sv
// tb/tb_framebuffer_scanout_reader.sv - bench for framebuffer_scanout_reader
// Reduced-geometry instance under a cycle scoreboard, default instance under a vector table.
module tb_framebuffer_scanout_reader;

  localparam int S_FBW = 6;
  localparam int S_FBH = 4;
  localparam int S_SC  = 3;
  localparam int S_HA  = 18;
  localparam int S_HFP = 2;
  localparam int S_HS  = 3;
  localparam int S_HBP = 3;
  localparam int S_VA  = 12;
  localparam int S_VFP = 2;
  localparam int S_VS  = 2;
  localparam int S_VBP = 2;
  localparam int S_HT  = S_HA + S_HFP + S_HS + S_HBP;
  localparam int S_VT  = S_VA + S_VFP + S_VS + S_VBP;
  localparam int S_N   = S_FBW * S_FBH;

  logic read_clock = 1'b0;
  logic reset      = 1'b1;
  always #5 read_clock = ~read_clock;

  logic [14:0] s_addr, b_addr;
  logic        s_q, b_q;
  logic [11:0] s_rgb, b_rgb;
  logic        s_hs, s_vs, s_act, s_fs;
  logic        b_hs, b_vs, b_act, b_fs;

  framebuffer_scanout_reader #(
    .FB_WIDTH(S_FBW), .FB_HEIGHT(S_FBH), .SCALE(S_SC),
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) u_small (
    .read_clock(read_clock), .reset(reset), .read_addr(s_addr), .q(s_q),
    .rgb(s_rgb), .hsync(s_hs), .vsync(s_vs), .active(s_act), .frame_start(s_fs)
  );

  framebuffer_scanout_reader u_full (
    .read_clock(read_clock), .reset(reset), .read_addr(b_addr), .q(b_q),
    .rgb(b_rgb), .hsync(b_hs), .vsync(b_vs), .active(b_act), .frame_start(b_fs)
  );

  logic s_mem [0:S_N-1];
  always @(posedge read_clock) s_q <= (int'(s_addr) < S_N) ? s_mem[s_addr] : 1'b0;

  function automatic logic writer_pix(int a);
    int x, y;
    x = a % 160;
    y = a / 160;
    return !((x >= 40) && (x <= 119) && (y >= 30) && (y <= 89));
  endfunction
  always @(posedge read_clock) b_q <= writer_pix(int'(b_addr));

  // reference raster position and read address for the reduced instance
  int          mh = 0, mv = 0;
  logic [14:0] rd_exp = '0;
  always @(posedge read_clock) begin
    if (reset) begin
      mh <= 0;
      mv <= 0;
      rd_exp <= '0;
    end else begin
      if (mh < S_HA && mv < S_VA) rd_exp <= 15'((mv / S_SC) * S_FBW + mh / S_SC);
      if (mh == S_HT - 1) begin
        mh <= 0;
        mv <= (mv == S_VT - 1) ? 0 : mv + 1;
      end else begin
        mh <= mh + 1;
      end
    end
  end

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        act;
    logic        fs;
  } out_t;

  localparam out_t IDLE = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, act: 1'b0, fs: 1'b0};

  function automatic out_t s_expect(int h, int v);
    out_t e;
    logic vis;
    vis   = (h < S_HA) && (v < S_VA);
    e.rgb = 12'h000;
    if (vis) e.rgb = s_mem[(v / S_SC) * S_FBW + h / S_SC] ? 12'hFFF : 12'h000;
    e.hs  = !((h >= S_HA + S_HFP) && (h < S_HA + S_HFP + S_HS));
    e.vs  = !((v >= S_VA + S_VFP) && (v < S_VA + S_VFP + S_VS));
    e.act = vis;
    e.fs  = (h == 0) && (v == 0);
    return e;
  endfunction

  int   n_vec = 0, n_err = 0;
  int   cyc = 0, last_fs = -1, hs_run = 0;
  out_t sb[$];

  always @(negedge read_clock) begin : scoreboard
    out_t got, e;
    cyc++;
    got = {s_rgb, s_hs, s_vs, s_act, s_fs};
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL s_out cyc=%0d got rgb=%h hs=%b vs=%b act=%b fs=%b want rgb=%h hs=%b vs=%b act=%b fs=%b",
                 cyc, got.rgb, got.hs, got.vs, got.act, got.fs, e.rgb, e.hs, e.vs, e.act, e.fs);
      end
      n_vec++;
      if (s_addr !== rd_exp) begin
        n_err++;
        $display("FAIL s_addr cyc=%0d got %0d want %0d", cyc, s_addr, rd_exp);
      end
    end
    if (s_fs === 1'b1) begin
      if (last_fs >= 0) begin
        n_vec++;
        if (cyc - last_fs != S_HT * S_VT) begin
          n_err++;
          $display("FAIL fs_period got %0d want %0d", cyc - last_fs, S_HT * S_VT);
        end
      end
      last_fs = cyc;
    end
    if (s_hs === 1'b0) begin
      hs_run++;
    end else begin
      if (hs_run > 0) begin
        n_vec++;
        if (hs_run != S_HS) begin
          n_err++;
          $display("FAIL hsync_width got %0d want %0d", hs_run, S_HS);
        end
      end
      hs_run = 0;
    end
    if (reset) begin
      last_fs = -1;
      sb.delete();
      repeat (3) sb.push_back(IDLE);
    end else begin
      sb.push_back(s_expect(mh, mv));
    end
  end

  typedef struct {
    int          k;
    logic [14:0] addr;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        act;
    logic        fs;
  } vec_t;

  localparam int NV = 15;
  vec_t tab [NV];

  task automatic wait_raster(input int h, input int v, input int limit, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(posedge read_clock);
      #1;
      if (mh == h && mv == v) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL %s timeout got none want h=%0d v=%0d", name, h, v);
    end
  endtask

  initial begin
    int idx;
    // k counts clocks from reset release; outputs lag the counters by 3, read_addr by 1
    tab[0]  = '{0,    15'd0,   12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
    tab[1]  = '{2,    15'd0,   12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
    tab[2]  = '{3,    15'd0,   12'hFFF, 1'b1, 1'b1, 1'b1, 1'b1};
    tab[3]  = '{4,    15'd0,   12'hFFF, 1'b1, 1'b1, 1'b1, 1'b0};
    tab[4]  = '{5,    15'd1,   12'hFFF, 1'b1, 1'b1, 1'b1, 1'b0};
    tab[5]  = '{642,  15'd159, 12'hFFF, 1'b1, 1'b1, 1'b1, 1'b0};
    tab[6]  = '{643,  15'd159, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
    tab[7]  = '{658,  15'd159, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
    tab[8]  = '{659,  15'd159, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0};
    tab[9]  = '{754,  15'd159, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0};
    tab[10] = '{755,  15'd159, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
    tab[11] = '{801,  15'd0,   12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
    tab[12] = '{803,  15'd0,   12'hFFF, 1'b1, 1'b1, 1'b1, 1'b0};
    tab[13] = '{3201, 15'd160, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
    tab[14] = '{3205, 15'd161, 12'hFFF, 1'b1, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < S_N; i++) s_mem[i] = 1'($urandom_range(0, 1));

    reset = 1'b1;
    repeat (5) @(posedge read_clock);
    #1 reset = 1'b0;

    idx = 0;
    for (int k = 0; k <= 3210; k++) begin
      @(negedge read_clock);
      while (idx < NV && tab[idx].k == k) begin
        n_vec++;
        if ({b_addr, b_rgb, b_hs, b_vs, b_act, b_fs} !==
            {tab[idx].addr, tab[idx].rgb, tab[idx].hs, tab[idx].vs, tab[idx].act, tab[idx].fs}) begin
          n_err++;
          $display("FAIL full_vec k=%0d got addr=%0d rgb=%h hs=%b vs=%b act=%b fs=%b want addr=%0d rgb=%h hs=%b vs=%b act=%b fs=%b",
                   k, b_addr, b_rgb, b_hs, b_vs, b_act, b_fs, tab[idx].addr, tab[idx].rgb,
                   tab[idx].hs, tab[idx].vs, tab[idx].act, tab[idx].fs);
        end
        idx++;
      end
    end

    // all-ones buffer: blanking must still read as 0 although the held address returns 1
    wait_raster(0, S_VA + 1, 2 * S_HT * S_VT, "vblank_wait");
    for (int i = 0; i < S_N; i++) s_mem[i] = 1'b1;
    repeat (2 * S_HT * S_VT) @(posedge read_clock);

    wait_raster(10, 5, 2 * S_HT * S_VT, "midframe_wait");
    reset = 1'b1;
    @(posedge read_clock);
    #1 reset = 1'b0;
    repeat (2 * S_HT * S_VT + 50) @(posedge read_clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
